// File: rtl/lab_design_seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e        : FSM state encoding (IDLE / RUN / ZERO)
//   DEFAULT_WIDTH  : default operand width, matching the 4-bit ALU
//   cnt_width()    : step-counter width for a given operand width
//   full_add()     : one-bit full adder, the building block of the subtractor
package lab_design_seq_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // One extra bit so the counter can hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    logic sum_v;
    logic cout_v;
    sum_v  = a ^ b ^ cin;
    cout_v = (a & b) | (cin & (a ^ b));
    return {cout_v, sum_v};
  endfunction

endpackage

// File: rtl/lab_design_seq_divider_if.sv
// Request/result bundle of the sequential divider.
//   start        : request, sampled only while the divider is idle
//   dividend     : unsigned dividend, captured on the accepted start
//   divisor      : unsigned divisor, captured on the accepted start
//   busy         : division in progress
//   done         : one-cycle pulse, results valid from this cycle on
//   quotient     : result, held until the next done
//   remainder    : result, held until the next done
//   div_by_zero  : qualifies the held results
// Modports: master drives requests (ALU side / bench), slave is the divider.
interface lab_design_seq_divider_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/lab_design_seq_divider_subtractor.sv
// Ripple-borrow subtractor built from full adders: diff = a - b computed as
// a + ~b + 1. borrow_out = 0 means a >= b.
//   a, b        : W-bit unsigned operands
//   diff        : W-bit difference (modulo 2^W)
//   borrow_out  : 1 when a < b
module lab_design_seq_divider_subtractor
  import lab_design_seq_divider_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W:0] carry_s;

  // Carry chain through inverted-b full adders; carry-in of 1 completes the two's complement.
  always_comb begin
    logic [1:0] fa_v;
    carry_s    = '0;
    diff       = '0;
    carry_s[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      fa_v           = full_add(a[i], ~b[i], carry_s[i]);
      diff[i]        = fa_v[0];
      carry_s[i + 1] = fa_v[1];
    end
    borrow_out = ~carry_s[W];
  end

endmodule

// File: rtl/lab_design_seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk   : single clock, all state changes on its rising edge
//   rst   : synchronous active-high reset
//   bus   : slave side of lab_design_seq_divider_if
//           (start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out)
// A nonzero division takes WIDTH RUN steps; a zero divisor takes a single
// ZERO step that returns quotient=all ones, remainder=dividend.
module lab_design_seq_divider
  import lab_design_seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  lab_design_seq_divider_if.slave   bus
);

  localparam int               CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [WIDTH-1:0] d_q,         d_d;          // working dividend, MSB-first
  logic [WIDTH:0]   p_q,         p_d;          // partial remainder
  logic [WIDTH-1:0] qs_q,        qs_d;         // quotient shift register
  logic [WIDTH-1:0] divisor_q,   divisor_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q,       dbz_d;
  logic             done_q,      done_d;
  logic             busy_q,      busy_d;

  logic [WIDTH:0]   p_shift_s;
  logic [WIDTH:0]   p_diff_s;
  logic             p_borrow_s;
  logic [WIDTH:0]   p_next_s;
  logic [WIDTH-1:0] qs_next_s;

  // After a restoring step P < divisor, so its top bit is always 0 and only
  // the low WIDTH bits feed the next shift.
  logic             unused_p_msb_s;
  assign unused_p_msb_s = p_q[WIDTH];

  // One restoring step: shift the next dividend bit into P, then trial-subtract.
  assign p_shift_s = {p_q[WIDTH-1:0], d_q[WIDTH-1]};

  lab_design_seq_divider_subtractor #(
    .W (WIDTH + 1)
  ) u_sub (
    .a          (p_shift_s),
    .b          ({1'b0, divisor_q}),
    .diff       (p_diff_s),
    .borrow_out (p_borrow_s)
  );

  // Restore (keep the shifted value) when the trial subtraction borrows.
  assign p_next_s  = p_borrow_s ? p_shift_s : p_diff_s;
  assign qs_next_s = {qs_q[WIDTH-2:0], ~p_borrow_s};

  // Next-state and datapath control for the IDLE / RUN / ZERO sequence.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    d_d         = d_q;
    p_d         = p_q;
    qs_d        = qs_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          d_d       = bus.dividend;
          divisor_d = bus.divisor;
          count_d   = '0;
          p_d       = '0;
          qs_d      = '0;
          if (bus.divisor == {WIDTH{1'b0}}) begin
            state_d = S_ZERO;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        p_d     = p_next_s;
        d_d     = {d_q[WIDTH-2:0], 1'b0};
        qs_d    = qs_next_s;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_STEP) begin
          quotient_d  = qs_next_s;
          remainder_d = p_next_s[WIDTH-1:0];
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end

      S_ZERO: begin
        // d_q still holds the untouched dividend here.
        quotient_d  = {WIDTH{1'b1}};
        remainder_d = d_q;
        dbz_d       = 1'b1;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      d_q         <= '0;
      p_q         <= '0;
      qs_q        <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      d_q         <= d_d;
      p_q         <= p_d;
      qs_q        <= qs_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
